// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one cache-to-memory block port among NUM_REQ caches.
// One transaction in flight; timeouts are flagged per response and stickily.
module mem_port_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_W     = 32,
    parameter int BLOCK_SIZE = 64,
    parameter int TIMEOUT    = 64,
    localparam int DW        = BLOCK_SIZE * 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DW-1:0]     req_wdata,
    output logic [NUM_REQ-1:0]        req_accept,
    output logic [NUM_REQ-1:0]        resp_valid,
    output logic [DW-1:0]             resp_rdata,
    output logic                      resp_err,
    output logic                      mem_req_valid,
    output logic                      mem_write,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DW-1:0]             mem_wdata,
    input  logic [DW-1:0]             mem_rdata,
    input  logic                      mem_ready,
    output logic                      err_sticky
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, WAIT_LOW, WAIT_HIGH, RESP} state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       last_q, last_d;
    logic [IW-1:0]       owner_q, owner_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [NUM_REQ-1:0]  req_accept_q, req_accept_d;
    logic [NUM_REQ-1:0]  resp_valid_q, resp_valid_d;
    logic                resp_err_q, resp_err_d;
    logic                err_sticky_q, err_sticky_d;
    logic                mem_req_valid_q, mem_req_valid_d;
    logic                mem_write_q, mem_write_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DW-1:0]       mem_wdata_q, mem_wdata_d;
    logic [DW-1:0]       resp_rdata_q, resp_rdata_d;

    logic                found;
    logic [IW-1:0]       win;
    logic [IW-1:0]       idx;
    logic                expired;

    // Scan upward from the slot after the last winner, wrapping around.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = IW'((int'(last_q) + k) % NUM_REQ);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign expired = (timer_q == TW'(TIMEOUT - 1));

    always_comb begin
        state_d         = state_q;
        last_d          = last_q;
        owner_d         = owner_q;
        timer_d         = timer_q;
        req_accept_d    = '0;
        resp_valid_d    = '0;
        resp_err_d      = 1'b0;
        err_sticky_d    = err_sticky_q;
        mem_req_valid_d = 1'b0;
        mem_write_d     = mem_write_q;
        mem_addr_d      = mem_addr_q;
        mem_wdata_d     = mem_wdata_q;
        resp_rdata_d    = resp_rdata_q;
        unique case (state_q)
            IDLE: begin
                if (mem_ready && found) begin
                    mem_write_d       = req_write[win];
                    mem_addr_d        = req_addr[int'(win)*ADDR_W +: ADDR_W];
                    mem_wdata_d       = req_wdata[int'(win)*DW +: DW];
                    owner_d           = win;
                    last_d            = win;
                    req_accept_d[win] = 1'b1;
                    mem_req_valid_d   = 1'b1;
                    timer_d           = '0;
                    state_d           = WAIT_LOW;
                end
            end
            WAIT_LOW, WAIT_HIGH: begin
                timer_d = timer_q + 1'b1;
                if (expired) begin
                    resp_valid_d[owner_q] = 1'b1;
                    resp_err_d            = 1'b1;
                    err_sticky_d          = 1'b1;
                    state_d               = RESP;
                end else if (state_q == WAIT_LOW) begin
                    if (!mem_ready) state_d = WAIT_HIGH;
                end else if (mem_ready) begin
                    if (!mem_write_q) resp_rdata_d = mem_rdata;
                    resp_valid_d[owner_q] = 1'b1;
                    state_d               = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            last_q          <= IW'(NUM_REQ - 1);
            owner_q         <= '0;
            timer_q         <= '0;
            req_accept_q    <= '0;
            resp_valid_q    <= '0;
            resp_err_q      <= 1'b0;
            err_sticky_q    <= 1'b0;
            mem_req_valid_q <= 1'b0;
            mem_write_q     <= 1'b0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
            resp_rdata_q    <= '0;
        end else begin
            state_q         <= state_d;
            last_q          <= last_d;
            owner_q         <= owner_d;
            timer_q         <= timer_d;
            req_accept_q    <= req_accept_d;
            resp_valid_q    <= resp_valid_d;
            resp_err_q      <= resp_err_d;
            err_sticky_q    <= err_sticky_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_write_q     <= mem_write_d;
            mem_addr_q      <= mem_addr_d;
            mem_wdata_q     <= mem_wdata_d;
            resp_rdata_q    <= resp_rdata_d;
        end
    end

    assign req_accept    = req_accept_q;
    assign resp_valid    = resp_valid_q;
    assign resp_err      = resp_err_q;
    assign err_sticky    = err_sticky_q;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_write     = mem_write_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign resp_rdata    = resp_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: grant order, handshake, data,
// timeout and reset-abort behaviour against a simple memory model.
module tb_mem_port_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 32;
    localparam int BSIZE   = 64;
    localparam int TIMEOUT = 64;
    localparam int DW      = BSIZE * 8;

    typedef struct {
        int              id;
        logic            wr;
        logic [31:0]     addr;
        logic [DW-1:0]   wdata;
        logic [DW-1:0]   rdata;
        logic            err;
    } item_t;

    logic                      clk;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DW-1:0]     req_wdata;
    logic [NUM_REQ-1:0]        req_accept;
    logic [NUM_REQ-1:0]        resp_valid;
    logic [DW-1:0]             resp_rdata;
    logic                      resp_err;
    logic                      mem_req_valid;
    logic                      mem_write;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DW-1:0]             mem_wdata;
    logic [DW-1:0]             mem_rdata;
    logic                      mem_ready;
    logic                      err_sticky;

    mem_port_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W),
        .BLOCK_SIZE(BSIZE), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_accept(req_accept), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_req_valid(mem_req_valid), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .err_sticky(err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int mem_delay = 3;
    logic hang = 1'b0;

    item_t exp_q [$];
    item_t txq [NUM_REQ][$];
    item_t cur;
    logic out_valid = 1'b0;
    logic [NUM_REQ-1:0] busy = '0;
    logic [DW-1:0] last_rd = '0;
    logic prev_mrv = 1'b0;

    logic [DW-1:0] exp_store [logic [31:0]];
    logic [DW-1:0] mem_store [logic [31:0]];
    logic [31:0]   mm_addr;
    logic          mm_wr;

    function automatic logic [DW-1:0] pat(input logic [31:0] a);
        return {16{a ^ 32'h5EED_0000}};
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input int id, input logic wr, input logic [31:0] a,
                        input logic [DW-1:0] d, input logic e);
        item_t it;
        it.id = id;
        it.wr = wr;
        it.addr = a;
        it.wdata = d;
        it.err = e;
        if (wr && !e) exp_store[a] = d;
        it.rdata = exp_store.exists(a) ? exp_store[a] : pat(a);
        exp_q.push_back(it);
        txq[id].push_back(it);
    endtask

    task automatic flush();
        exp_q.delete();
        for (int i = 0; i < NUM_REQ; i++) txq[i].delete();
        out_valid = 1'b0;
        busy = '0;
        req_valid = '0;
        last_rd = '0;
        prev_mrv = 1'b0;
    endtask

    task automatic check_reset_outs();
        chk("rst_accept", req_accept, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_sticky", err_sticky, 0);
        chk("rst_mrv", mem_req_valid, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_rdata", resp_rdata, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        flush();
        repeat (2) @(negedge clk);
        check_reset_outs();
        rst = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || out_valid) && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("drain", (exp_q.size() == 0 && !out_valid), 1);
        if (exp_q.size() != 0 || out_valid) begin
            exp_q.delete();
            for (int i = 0; i < NUM_REQ; i++) txq[i].delete();
            out_valid = 1'b0;
            busy = '0;
            req_valid = '0;
        end
        repeat (2) @(negedge clk);
    endtask

    // Memory model: drops ready on a request, raises it after mem_delay cycles.
    initial begin
        mem_ready = 1'b1;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_req_valid && !hang && !rst) begin
                mem_ready = 1'b0;
                mm_addr = mem_addr;
                mm_wr = mem_write;
                if (mm_wr) mem_store[mm_addr] = mem_wdata;
                repeat (mem_delay) @(negedge clk);
                if (mm_wr) mem_rdata = ~pat(mm_addr);
                else mem_rdata = mem_store.exists(mm_addr) ?
                                 mem_store[mm_addr] : pat(mm_addr);
                mem_ready = 1'b1;
            end
        end
    end

    // Monitor and requester driver.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                if (mem_req_valid) chk("mrv_single", prev_mrv, 0);
                prev_mrv = mem_req_valid;
                if (req_accept != '0) begin
                    chk("acc_busy", out_valid, 0);
                    chk("acc_resp_overlap", resp_valid, 0);
                    if (exp_q.size() == 0) begin
                        chk("acc_unexp", req_accept, 0);
                    end else begin
                        cur = exp_q.pop_front();
                        chk("acc_vec", req_accept, NUM_REQ'(1) << cur.id);
                        chk("acc_mrv", mem_req_valid, 1);
                        chk("acc_addr", mem_addr, cur.addr);
                        chk("acc_write", mem_write, cur.wr);
                        if (cur.wr) chk("acc_wdata", mem_wdata, cur.wdata);
                        req_valid[cur.id] = 1'b0;
                        busy[cur.id] = 1'b1;
                        out_valid = 1'b1;
                        acc_cyc = cyc;
                    end
                end
                if (resp_valid != '0) begin
                    if (!out_valid) begin
                        chk("resp_unexp", resp_valid, 0);
                    end else begin
                        chk("resp_vec", resp_valid, NUM_REQ'(1) << cur.id);
                        chk("resp_err", resp_err, cur.err);
                        if (cur.wr || cur.err) begin
                            chk("resp_rdata_hold", resp_rdata, last_rd);
                        end else begin
                            chk("resp_rdata", resp_rdata, cur.rdata);
                            last_rd = cur.rdata;
                        end
                        if (cur.err) chk("to_latency", cyc - acc_cyc, TIMEOUT);
                        busy[cur.id] = 1'b0;
                        out_valid = 1'b0;
                    end
                end
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (!req_valid[i] && !busy[i] && txq[i].size() != 0) begin
                        req_valid[i] = 1'b1;
                        req_write[i] = txq[i][0].wr;
                        req_addr[i*ADDR_W +: ADDR_W] = txq[i][0].addr;
                        req_wdata[i*DW +: DW] = txq[i][0].wdata;
                        void'(txq[i].pop_front());
                    end
                end
            end
        end
    end

    initial begin
        int k;
        rst = 1'b1;
        req_valid = '0;
        req_write = '0;
        req_addr = '0;
        req_wdata = '0;
        do_reset();

        // Single read from requester 2
        push(2, 1'b0, 32'h40, '0, 1'b0);
        wait_done(100);

        // All four at once, then 0 and 3 again
        do_reset();
        for (int i = 0; i < NUM_REQ; i++)
            push(i, 1'b0, 32'h1000 + 32'(i) * 32'h40, '0, 1'b0);
        wait_done(200);
        push(0, 1'b0, 32'h2000, '0, 1'b0);
        push(3, 1'b0, 32'h2040, '0, 1'b0);
        wait_done(100);

        // Write then read back from requester 1
        push(1, 1'b1, 32'h80, {64{8'hA5}}, 1'b0);
        push(1, 1'b0, 32'h80, '0, 1'b0);
        wait_done(100);

        // Memory never drops ready: timeout
        hang = 1'b1;
        push(2, 1'b0, 32'h100, '0, 1'b1);
        wait_done(200);
        chk("sticky_set", err_sticky, 1);
        hang = 1'b0;
        push(0, 1'b0, 32'h140, '0, 1'b0);
        wait_done(100);
        chk("sticky_hold", err_sticky, 1);
        do_reset();

        // Reset in the middle of requester 3's read
        mem_delay = 10;
        push(3, 1'b0, 32'h300, '0, 1'b0);
        k = 0;
        while (!out_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("abort_accept", out_valid, 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        flush();
        @(negedge clk);
        check_reset_outs();
        rst = 1'b0;
        repeat (15) @(negedge clk);
        mem_delay = 3;
        push(0, 1'b0, 32'h500, '0, 1'b0);
        push(2, 1'b0, 32'h540, '0, 1'b0);
        wait_done(100);

        // Continuous 0/1 traffic alternates
        do_reset();
        for (int i = 0; i < 10; i++) begin
            push(0, 1'b0, 32'h4000 + 32'(i) * 32'h40, '0, 1'b0);
            push(1, 1'b0, 32'h8000 + 32'(i) * 32'h40, '0, 1'b0);
        end
        wait_done(600);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
